l2_request_arbiter: RTL and testbench

L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

---
 rtl/l2_request_arbiter_pkg.sv | 43 ++++
 rtl/l2_request_arbiter_if.sv | 29 ++
 rtl/l2_request_arbiter_rr_arbiter.sv | 48 ++++
 rtl/l2_request_arbiter.sv | 100 ++++++++++
 tb/tb_l2_request_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_request_arbiter_pkg.sv
// Shared L2 request defines: packet layout, cache line type and request type encodings.
package l2_request_arbiter_pkg;

  localparam int unsigned CACHE_LINE_BYTES = 64;
  localparam int unsigned CACHE_LINE_BITS  = CACHE_LINE_BYTES * 8;
  localparam int unsigned CORE_ID_WIDTH    = 4;
  localparam int unsigned L2_ID_WIDTH      = 2;
  localparam int unsigned L2_ADDR_WIDTH    = 26;
  localparam int unsigned MAX_CORES        = 16;

  typedef logic [CACHE_LINE_BITS-1:0]  cache_line_data_t;
  typedef logic [CACHE_LINE_BYTES-1:0] cache_line_mask_t;
  typedef logic [CORE_ID_WIDTH-1:0]    core_id_t;
  typedef logic [L2_ID_WIDTH-1:0]      l2_id_t;
  typedef logic [L2_ADDR_WIDTH-1:0]    l2_addr_t;

  typedef enum logic [2:0] {
    L2REQ_LOAD,
    L2REQ_STORE,
    L2REQ_LOAD_SYNC,
    L2REQ_STORE_SYNC,
    L2REQ_FLUSH,
    L2REQ_IINVALIDATE,
    L2REQ_DINVALIDATE
  } l2req_packet_type_t;

  typedef enum logic {
    CT_ICACHE,
    CT_DCACHE
  } cache_type_t;

  typedef struct packed {
    logic               valid;
    core_id_t           core;
    l2_id_t             id;
    l2req_packet_type_t packet_type;
    cache_type_t        cache_type;
    l2_addr_t           address;
    cache_line_data_t   data;
    cache_line_mask_t   store_mask;
  } l2req_packet_t;

endpackage

// File: rtl/l2_request_arbiter_if.sv
// Core-request, restart and L2 tag-stage signals of the L2 request arbiter.
interface l2_request_arbiter_if #(
  parameter int unsigned NUM_CORES = 4
);
  import l2_request_arbiter_pkg::*;

  l2req_packet_t          l2i_request [NUM_CORES];
  logic [NUM_CORES-1:0]   l2_ready;
  l2req_packet_t          restart_request;
  cache_line_data_t       restart_data;
  logic                   restart_ack;
  logic                   l2_stall;
  l2req_packet_t          l2a_request;
  logic                   l2a_is_restart;
  cache_line_data_t       l2a_fill_data;

  // Environment side: cores, fill path and downstream tag stage.
  modport master (
    output l2i_request, restart_request, restart_data, l2_stall,
    input  l2_ready, restart_ack, l2a_request, l2a_is_restart, l2a_fill_data
  );

  // Arbiter side.
  modport slave (
    input  l2i_request, restart_request, restart_data, l2_stall,
    output l2_ready, restart_ack, l2a_request, l2a_is_restart, l2a_fill_data
  );

endinterface

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant searched from rr_ptr, pointer advances past the winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int unsigned PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQUESTERS);
      if (!found && request[idx]) begin
        found         = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr = '0;
    if (32'(grant_idx) + 32'd1 != NUM_REQUESTERS)
      next_ptr = PTR_W'(32'(grant_idx) + 32'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (update_lru)
      rr_ptr <= next_ptr;
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// L2 request arbiter: restart path has absolute priority, cores share the rest round-robin.
module l2_request_arbiter #(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_request_arbiter_if.slave   l2
);
  import l2_request_arbiter_pkg::*;

  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_HOLD,
    SRC_CORE,
    SRC_RESTART
  } beat_src_e;

  beat_src_e            beat_src;
  logic [NUM_CORES-1:0] core_valid;
  logic [NUM_CORES-1:0] arb_request;
  logic [NUM_CORES-1:0] grant_oh;
  logic                 grant_window;
  l2req_packet_t        granted_pkt;

  always_comb begin
    core_valid = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      core_valid[i] = l2.l2i_request[i].valid;
  end

  // Cores only compete when neither a stall nor a restart owns the slot, so the
  // pointer advances exactly on cycles that actually grant a core.
  assign grant_window = !l2.l2_stall && !l2.restart_request.valid;
  assign arb_request  = grant_window ? core_valid : '0;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_CORES)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .request   (arb_request),
    .update_lru(|arb_request),
    .grant_oh  (grant_oh)
  );

  always_comb begin
    granted_pkt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      if (grant_oh[i])
        granted_pkt = l2.l2i_request[i];
  end

  assign l2.l2_ready    = grant_oh;
  assign l2.restart_ack = l2.restart_request.valid && !l2.l2_stall;

  always_comb begin
    beat_src = SRC_IDLE;
    if (l2.l2_stall)
      beat_src = SRC_HOLD;
    else if (l2.restart_request.valid)
      beat_src = SRC_RESTART;
    else if (|grant_oh)
      beat_src = SRC_CORE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l2.l2a_request    <= '0;
      l2.l2a_is_restart <= 1'b0;
      l2.l2a_fill_data  <= '0;
    end else begin
      case (beat_src)
        SRC_RESTART: begin
          l2.l2a_request    <= l2.restart_request;
          l2.l2a_is_restart <= 1'b1;
          l2.l2a_fill_data  <= l2.restart_data;
        end
        SRC_CORE: begin
          l2.l2a_request    <= granted_pkt;
          l2.l2a_is_restart <= 1'b0;
          l2.l2a_fill_data  <= '0;
        end
        SRC_HOLD: ;
        default: begin
          l2.l2a_request    <= '0;
          l2.l2a_is_restart <= 1'b0;
          l2.l2a_fill_data  <= '0;
        end
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(l2.l2_ready));

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core_id
    a_core_id: assert property (@(posedge clk) disable iff (reset)
      l2.l2i_request[i].valid |-> (l2.l2i_request[i].core == core_id_t'(i)));
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: directed scenarios plus a random scoreboard run.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int NC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  l2_request_arbiter_if #(.NUM_CORES(NC)) l2 ();

  l2_request_arbiter #(.NUM_CORES(NC)) dut (
    .clk  (clk),
    .reset(reset),
    .l2   (l2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // loose: an idle beat only pins valid; all other fields are don't-care
  task automatic check_pkt(input string name, input l2req_packet_t act, input l2req_packet_t exp,
                           input logic loose);
    n_checks++;
    if (loose ? (act.valid !== exp.valid) : (act !== exp)) begin
      n_errors++;
      $display("FAIL %s: got v=%0b core=%0d addr=%h data_lo=%h expected v=%0b core=%0d addr=%h data_lo=%h",
               name, act.valid, act.core, act.address, act.data[63:0],
               exp.valid, exp.core, exp.address, exp.data[63:0]);
    end
  endtask

  function automatic l2req_packet_t make_pkt(input int core);
    l2req_packet_t p;
    p.valid       = 1'b1;
    p.core        = core_id_t'(core);
    p.id          = l2_id_t'($urandom());
    p.packet_type = l2req_packet_type_t'($urandom_range(0, 6));
    p.cache_type  = cache_type_t'($urandom_range(0, 1));
    p.address     = l2_addr_t'($urandom());
    for (int w = 0; w < 16; w++) p.data[w*32 +: 32] = $urandom();
    p.store_mask  = {$urandom(), $urandom()};
    return p;
  endfunction

  function automatic cache_line_data_t make_line();
    cache_line_data_t d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  logic             chk_on = 1'b0;
  logic             sb_en  = 1'b0;
  l2req_packet_t    m_req;
  logic             m_loose;
  logic             m_is_rst;
  cache_line_data_t m_fill;
  int               m_ptr;
  int               sb_pending = -1;
  l2req_packet_t    sb_q [NC][$];
  int               wait_cnt [NC];

  always @(negedge clk) begin
    if (chk_on) begin
      int               g;
      logic [NC-1:0]    exp_ready;
      logic             exp_ack;
      logic             opp;
      l2req_packet_t    popped;
      if (reset) begin
        m_req = '0; m_loose = 1'b0; m_is_rst = 1'b0; m_fill = '0; m_ptr = 0; sb_pending = -1;
      end
      check_pkt("l2a_request", l2.l2a_request, m_req, m_loose);
      check("l2a_is_restart", 64'(l2.l2a_is_restart), 64'(m_is_rst));
      n_checks++;
      if (!m_loose && l2.l2a_fill_data !== m_fill) begin
        n_errors++;
        $display("FAIL l2a_fill_data: got lo %h expected lo %h", l2.l2a_fill_data[63:0], m_fill[63:0]);
      end
      if (sb_pending >= 0) begin
        n_checks++;
        if (sb_q[sb_pending].size() == 0) begin
          n_errors++;
          $display("FAIL sb_extra: core %0d beat got 1 expected 0 outstanding", sb_pending);
        end else begin
          popped = sb_q[sb_pending].pop_front();
          if (l2.l2a_request !== popped) begin
            n_errors++;
            $display("FAIL sb_fields: core %0d got addr=%h id=%0d expected addr=%h id=%0d",
                     sb_pending, l2.l2a_request.address, l2.l2a_request.id, popped.address, popped.id);
          end
        end
        sb_pending = -1;
      end

      g = -1; exp_ack = 1'b0;
      if (!l2.l2_stall) begin
        if (l2.restart_request.valid) exp_ack = 1'b1;
        else
          for (int k = 0; k < NC; k++)
            if (g < 0 && l2.l2i_request[(m_ptr + k) % NC].valid) g = (m_ptr + k) % NC;
      end
      exp_ready = (g >= 0) ? (NC'(1) << g) : '0;
      check("l2_ready", 64'(l2.l2_ready), 64'(exp_ready));
      check("restart_ack", 64'(l2.restart_ack), 64'(exp_ack));

      opp = !reset && !l2.l2_stall && !l2.restart_request.valid;
      if (sb_en && opp)
        for (int i = 0; i < NC; i++)
          if (l2.l2i_request[i].valid) begin
            wait_cnt[i]++;
            if (l2.l2_ready[i]) begin
              n_checks++;
              if (wait_cnt[i] > NC) begin
                n_errors++;
                $display("FAIL wait_bound: core %0d waited %0d expected <= %0d", i, wait_cnt[i], NC);
              end
              wait_cnt[i] = 0;
            end
          end

      if (!reset && !l2.l2_stall) begin
        if (l2.restart_request.valid) begin
          m_req = l2.restart_request; m_loose = 1'b0; m_is_rst = 1'b1; m_fill = l2.restart_data;
        end else if (g >= 0) begin
          m_req = l2.l2i_request[g]; m_loose = 1'b0; m_is_rst = 1'b0; m_fill = '0;
          m_ptr = (g + 1) % NC;
          if (sb_en) sb_pending = g;
        end else begin
          m_req = '0; m_loose = 1'b1; m_is_rst = 1'b0; m_fill = '0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NC; i++) l2.l2i_request[i] = '0;
    l2.restart_request = '0;
    l2.restart_data    = '0;
    l2.l2_stall        = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    l2req_packet_t    p;
    l2req_packet_t    rpkt;
    cache_line_data_t rdata;
    logic [NC-1:0]    rdy;
    logic             rack;
    int               got;
    int               outstanding;
    logic             drained;

    clear_inputs();
    tick();
    chk_on = 1'b1;
    tick();
    reset = 1'b0;

    // reset state
    check("rst_valid", 64'(l2.l2a_request.valid), 64'd0);
    check("rst_pkt_zero", 64'(l2.l2a_request == '0), 64'd1);
    check("rst_is_restart", 64'(l2.l2a_is_restart), 64'd0);
    check("rst_fill_zero", 64'(l2.l2a_fill_data == '0), 64'd1);
    check("rst_rr_ptr", 64'(dut.u_arb.rr_ptr), 64'd0);

    // single request from core 2
    do_reset();
    p = make_pkt(2); p.address = 26'h1000;
    l2.l2i_request[2] = p;
    #1;
    check("s1_ready", 64'(l2.l2_ready), 64'h4);
    tick();
    l2.l2i_request[2] = '0;
    check("s1_addr", 64'(l2.l2a_request.address), 64'h1000);
    check("s1_core", 64'(l2.l2a_request.core), 64'd2);
    check("s1_valid", 64'(l2.l2a_request.valid), 64'd1);
    check("s1_rr_ptr", 64'(dut.u_arb.rr_ptr), 64'd3);
    tick();
    check("s1_idle_valid", 64'(l2.l2a_request.valid), 64'd0);

    // all cores continuously requesting
    do_reset();
    for (int i = 0; i < NC; i++) l2.l2i_request[i] = make_pkt(i);
    for (int n = 0; n < 8; n++) begin
      #1;
      rdy = l2.l2_ready;
      got = 99;
      for (int i = 0; i < NC; i++) if (rdy[i]) got = i;
      check("rr_order", 64'(got), 64'(n % NC));
      tick();
      for (int i = 0; i < NC; i++) if (rdy[i]) l2.l2i_request[i] = make_pkt(i);
    end
    clear_inputs();

    // restart pre-empts cores 0 and 1
    do_reset();
    rpkt = make_pkt(1); rdata = make_line();
    l2.restart_request = rpkt; l2.restart_data = rdata;
    l2.l2i_request[0] = make_pkt(0);
    l2.l2i_request[1] = make_pkt(1);
    #1;
    check("s3_ack", 64'(l2.restart_ack), 64'd1);
    check("s3_ready", 64'(l2.l2_ready), 64'd0);
    tick();
    l2.restart_request = '0;
    check("s3_is_restart", 64'(l2.l2a_is_restart), 64'd1);
    check("s3_fill", 64'(l2.l2a_fill_data == rdata), 64'd1);
    check("s3_req_addr", 64'(l2.l2a_request.address), 64'(rpkt.address));
    #1;
    check("s3_ready_core0", 64'(l2.l2_ready), 64'h1);
    check("s3_ack_clear", 64'(l2.restart_ack), 64'd0);
    tick();
    l2.l2i_request[0] = '0;
    check("s3_core0_beat", 64'(l2.l2a_request.core), 64'd0);
    check("s3_core0_not_restart", 64'(l2.l2a_is_restart), 64'd0);
    #1;
    check("s3_ready_core1", 64'(l2.l2_ready), 64'h2);
    tick();
    l2.l2i_request[1] = '0;

    // three stalled cycles with core 1 waiting
    do_reset();
    l2.l2i_request[0] = make_pkt(0);
    tick();
    l2.l2i_request[0] = '0;
    l2.l2i_request[1] = make_pkt(1);
    l2.l2_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("s4_stall_ready", 64'(l2.l2_ready), 64'd0);
      check("s4_hold_core", 64'(l2.l2a_request.core), 64'd0);
      check("s4_hold_valid", 64'(l2.l2a_request.valid), 64'd1);
      tick();
    end
    l2.l2_stall = 1'b0;
    #1;
    check("s4_hold_after", 64'(l2.l2a_request.core), 64'd0);
    check("s4_ready_core1", 64'(l2.l2_ready), 64'h2);
    tick();
    l2.l2i_request[1] = '0;
    check("s4_core1_beat", 64'(l2.l2a_request.core), 64'd1);

    // reset while a beat is registered
    l2.l2i_request[0] = make_pkt(0);
    tick();
    l2.l2i_request[0] = '0;
    check("s5_beat_before", 64'(l2.l2a_request.valid), 64'd1);
    reset = 1'b1;
    #1;
    check("s5_valid_cleared", 64'(l2.l2a_request.valid), 64'd0);
    check("s5_ptr_cleared", 64'(dut.u_arb.rr_ptr), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    l2.l2i_request[3] = make_pkt(3);
    #1;
    check("s5_ready_core3", 64'(l2.l2_ready), 64'h8);
    tick();
    l2.l2i_request[3] = '0;
    check("s5_core3_beat", 64'(l2.l2a_request.core), 64'd3);
    check("s5_rr_ptr", 64'(dut.u_arb.rr_ptr), 64'd0);

    // random traffic with scoreboard
    do_reset();
    for (int i = 0; i < NC; i++) wait_cnt[i] = 0;
    sb_en = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      #1;
      rdy = l2.l2_ready; rack = l2.restart_ack;
      tick();
      for (int i = 0; i < NC; i++)
        if (!l2.l2i_request[i].valid || rdy[i]) begin
          if ($urandom_range(0, 99) < 70) begin
            p = make_pkt(i);
            l2.l2i_request[i] = p;
            sb_q[i].push_back(p);
          end else begin
            l2.l2i_request[i] = '0;
          end
        end
      if (!l2.restart_request.valid || rack) begin
        if ($urandom_range(0, 99) < 8) begin
          l2.restart_request = make_pkt($urandom_range(0, NC - 1));
          l2.restart_data    = make_line();
        end else begin
          l2.restart_request = '0;
        end
      end
      l2.l2_stall = ($urandom_range(0, 99) < 15);
    end

    l2.l2_stall = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 200 && !drained; c++) begin
      #1;
      rdy = l2.l2_ready; rack = l2.restart_ack;
      tick();
      for (int i = 0; i < NC; i++) if (rdy[i]) l2.l2i_request[i] = '0;
      if (rack) l2.restart_request = '0;
      drained = !l2.restart_request.valid;
      for (int i = 0; i < NC; i++) if (l2.l2i_request[i].valid) drained = 1'b0;
    end
    check("drain_done", 64'(drained), 64'd1);
    tick();
    tick();
    outstanding = 0;
    for (int i = 0; i < NC; i++) outstanding += sb_q[i].size();
    check("sb_outstanding", 64'(outstanding), 64'd0);
    sb_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
